fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int          XLEN_P    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FAULT
    } fetch_state;

    typedef struct packed {
        logic [XLEN_P-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count. The element type is a
// parameter so the same block serves as the instruction buffer and as the
// outstanding-request PC queue. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module fetch_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    input  logic          flush,
    output T              head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Qualify push/pop against occupancy; flush overrides both.
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && !flush && ((count < FULL) || do_pop);
    end

    // Pointer and count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to a pipelined
// in-order memory, buffers responses with their PCs and hands them to decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_BOOT  | first cycle after reset, no request
// S_FETCH | normal fetching, requests limited by free buffer credits
// S_FAULT | misaligned redirect seen, no requests until aligned redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            fetch_fault_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    fetch_state      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   kill_q;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   fifo_cnt;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry      head;
    fetch_entry      rsp_entry;
    logic            fire_req;
    logic            rsp_valid;
    logic            push_fifo;
    logic            pop_fifo;

    // Request and handshake qualifiers; the request depends on registers only.
    always_comb begin
        imem_req_o = (state_q == S_FETCH) &&
                     (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < CREDITS);
        fire_req   = imem_req_o && imem_gnt_i;
        rsp_valid  = imem_rvalid_i && (out_cnt != '0);
        push_fifo  = rsp_valid && (kill_q == '0) && !redirect_i;
        pop_fifo   = instr_valid_o && instr_ready_i && !redirect_i;
        out_next   = out_cnt + CW'(fire_req) - CW'(rsp_valid);
        rsp_entry  = '{pc: rsp_pc, instr: imem_rdata_i};
    end

    // PCs of requests still awaiting their response; its count is the
    // number of outstanding requests.
    fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fire_req),
        .wdata (pc_q),
        .pop   (rsp_valid),
        .flush (1'b0),
        .head  (rsp_pc),
        .count (out_cnt)
    );

    fetch_fifo #(.T(fetch_entry), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_fifo),
        .wdata (rsp_entry),
        .pop   (pop_fifo),
        .flush (redirect_i),
        .head  (head),
        .count (fifo_cnt)
    );

    // PC and kill counter; a redirect kills every request still in flight,
    // including one granted in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            kill_q <= '0;
        end else begin
            if (redirect_i)    pc_q <= redirect_target_i;
            else if (fire_req) pc_q <= pc_q + XLEN'(4);

            if (redirect_i)                       kill_q <= out_next;
            else if (rsp_valid && kill_q != '0)   kill_q <= kill_q - 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_BOOT;
        else       state_q <= state_d;
    end

    // Next-state logic; a redirect decides fetch versus fault from alignment.
    always_comb begin
        state_d = state_q;
        if (state_q == S_BOOT) state_d = S_FETCH;
        if (redirect_i) begin
            state_d = (redirect_target_i[1:0] != 2'b00) ? S_FAULT : S_FETCH;
        end
    end

    // Consumer-facing outputs, masked when the buffer is empty.
    always_comb begin
        instr_valid_o = (fifo_cnt != '0);
        instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
        pc_o          = instr_valid_o ? head.pc : '0;
        pc_plus4_o    = pc_o + XLEN'(4);
        imem_addr_o   = pc_q;
        fetch_fault_o = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with adjustable
// latency and grant control, plus a scoreboard of expected {pc, instr}.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        fetch_fault_o;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_gnt_i        (imem_gnt_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .instr_valid_o     (instr_valid_o),
        .instr_o           (instr_o),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .instr_ready_i     (instr_ready_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fetch_fault_o     (fetch_fault_o)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, account for the handshakes that
    // the coming edge will perform, then advance to the next falling edge.
    task automatic step();
        exp_t e;
        if (rst_i) begin
            mem_q.delete();
            exp_q.delete();
            model_pc      = 32'h0;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_data(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
            if (imem_req_o) check("req_addr", imem_addr_o, model_pc);
            if (imem_req_o && imem_gnt_i) begin
                mem_q.push_back('{addr: imem_addr_o, due: cyc + lat});
                exp_q.push_back('{pc: model_pc, instr: mem_data(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            if (redirect_i) begin
                exp_q.delete();
                model_pc = redirect_target_i;
            end else if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'(instr_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc_o, e.pc);
                    check("sb_instr", instr_o, e.instr);
                    check("sb_pc_plus4", pc_plus4_o, e.pc + 32'd4);
                end
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!instr_valid_o && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(instr_valid_o), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_i        = 1'b1;
        redirect_target_i = target;
        step();
        redirect_i        = 1'b0;
    endtask

    initial begin
        int n;
        rst_i             = 1'b1;
        imem_gnt_i        = 1'b1;
        imem_rvalid_i     = 1'b0;
        imem_rdata_i      = '0;
        instr_ready_i     = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = '0;
        @(negedge clk_i);

        // Reset: two cycles high.
        step();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0);
        check("rst_fault", 32'(fetch_fault_o), 32'd0);
        step();
        rst_i = 1'b0;

        // Boot cycle, then first fetch with consumer stalled.
        check("boot_req", 32'(imem_req_o), 32'd0);
        step();
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, 32'h0);
        step();
        check("second_addr", imem_addr_o, 32'h4);
        step();
        check("first_valid", 32'(instr_valid_o), 32'd1);
        check("first_instr", instr_o, 32'h0010_0093);
        check("first_pc", pc_o, 32'h0);
        check("first_pc4", pc_plus4_o, 32'h4);
        check("bp_req_low0", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_req_low", 32'(imem_req_o), 32'd0);
            check("bp_head_pc", pc_o, 32'h0);
        end

        // Release backpressure; 0x8 should be requested the next cycle.
        instr_ready_i = 1'b1;
        step();
        check("release_req", 32'(imem_req_o), 32'd1);
        check("release_addr", imem_addr_o, 32'h8);

        // Grant stall at 0x8.
        imem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr_o, 32'h8);
        end
        imem_gnt_i = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Redirect with two responses in flight.
        lat = 3;
        n = 0;
        while (mem_q.size() != 2 && n < 40) begin
            step();
            n++;
        end
        check("two_in_flight", 32'(mem_q.size()), 32'd2);
        redirect(32'h100);
        check("redir_flushed", 32'(instr_valid_o), 32'd0);
        wait_valid("redir_wait", 40);
        check("redir_pc", pc_o, 32'h100);
        check("redir_instr", instr_o, mem_data(32'h100));

        // Redirect with a non-empty buffer and one response in flight.
        instr_ready_i = 1'b0;
        n = 0;
        while (!(instr_valid_o && mem_q.size() == 1) && n < 40) begin
            step();
            n++;
        end
        check("fifo_nonempty", 32'(instr_valid_o), 32'd1);
        redirect(32'h180);
        check("redir2_flushed", 32'(instr_valid_o), 32'd0);
        instr_ready_i = 1'b1;
        wait_valid("redir2_wait", 40);
        check("redir2_pc", pc_o, 32'h180);

        // Redirect in the same cycle as a response and a grant.
        lat = 1;
        n = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc && imem_req_o && imem_gnt_i)
               && n < 40) begin
            step();
            n++;
        end
        check("coincide_found", 32'(imem_req_o), 32'd1);
        redirect(32'h300);
        check("coincide_flushed", 32'(instr_valid_o), 32'd0);
        wait_valid("coincide_wait", 40);
        check("coincide_pc", pc_o, 32'h300);
        check("coincide_instr", instr_o, mem_data(32'h300));

        // Misaligned target faults and blocks requests.
        redirect(32'h102);
        check("fault_set", 32'(fetch_fault_o), 32'd1);
        check("fault_req", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_req_hold", 32'(imem_req_o), 32'd0);
            check("fault_sticky", 32'(fetch_fault_o), 32'd1);
        end
        redirect(32'h200);
        check("fault_clear", 32'(fetch_fault_o), 32'd0);
        check("recover_req", 32'(imem_req_o), 32'd1);
        check("recover_addr", imem_addr_o, 32'h200);
        wait_valid("recover_wait", 40);
        check("recover_pc", pc_o, 32'h200);

        // PC wrap-around.
        redirect(32'hFFFF_FFF8);
        n = 0;
        while (!(instr_valid_o && pc_o == 32'hFFFF_FFFC) && n < 40) begin
            step();
            n++;
        end
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4_o, 32'h0);
        for (int i = 0; i < 8; i++) step();
        check("wrap_req_addr_low", 32'(imem_addr_o < 32'h100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
